// File: rtl/axi_slave_stub_mem.sv
// Stub memory responder: byte-masked writes, one-cycle read latency,
// out-of-range error pulses and in-range traffic counters.
module axi_slave_stub_mem #(
  parameter int          ADDR_BITS  = 32,
  parameter int          DATA_BITS  = 64,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   WR,
  input  logic [ADDR_BITS-1:0]   ADDR_WR,
  input  logic [DATA_BITS-1:0]   DIN,
  input  logic [DATA_BITS/8-1:0] BSEL,
  input  logic                   RD,
  input  logic [ADDR_BITS-1:0]   ADDR_RD,
  output logic [DATA_BITS-1:0]   DOUT,
  output logic                   DOUT_VALID,
  output logic                   ERR_WR,
  output logic                   ERR_RD,
  output logic [31:0]            WR_CNT,
  output logic [31:0]            RD_CNT
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int HI     = LSB + DEPTH_LOG2;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DATA_BITS-1:0] ERR_WORD = DATA_BITS'(ERR_DATA);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  wr_oor;
  logic                  rd_oor;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_BITS-1:0]  rd_word;
  logic                  unused_low_bits;

  assign wr_idx = ADDR_WR[LSB +: DEPTH_LOG2];
  assign rd_idx = ADDR_RD[LSB +: DEPTH_LOG2];
  assign wr_oor = |(ADDR_WR >> HI);
  assign rd_oor = |(ADDR_RD >> HI);
  assign wr_ok  = WR && !wr_oor;
  assign rd_ok  = RD && !rd_oor;
  assign unused_low_bits = ^{ADDR_WR[LSB-1:0], ADDR_RD[LSB-1:0]};

  // Same-word collision is write-first: merge the incoming bytes into the read path.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_ok && (wr_idx == rd_idx)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (BSEL[i]) rd_word[8*i +: 8] = DIN[8*i +: 8];
      end
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (BSEL[i]) mem[wr_idx][8*i +: 8] <= DIN[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      ERR_WR     <= 1'b0;
      ERR_RD     <= 1'b0;
      WR_CNT     <= '0;
      RD_CNT     <= '0;
    end else begin
      DOUT_VALID <= RD;
      ERR_WR     <= WR && wr_oor;
      ERR_RD     <= RD && rd_oor;
      if (RD)    DOUT   <= rd_oor ? ERR_WORD : rd_word;
      if (wr_ok) WR_CNT <= WR_CNT + 32'd1;
      if (rd_ok) RD_CNT <= RD_CNT + 32'd1;
    end
  end

endmodule

// File: tb/tb_axi_slave_stub_mem.sv
// Table-driven bench for axi_slave_stub_mem with a read-response scoreboard.
module tb_axi_slave_stub_mem;

  logic        clk;
  logic        reset;
  logic        WR;
  logic [31:0] ADDR_WR;
  logic [63:0] DIN;
  logic [7:0]  BSEL;
  logic        RD;
  logic [31:0] ADDR_RD;
  logic [63:0] DOUT;
  logic        DOUT_VALID;
  logic        ERR_WR;
  logic        ERR_RD;
  logic [31:0] WR_CNT;
  logic [31:0] RD_CNT;

  axi_slave_stub_mem dut (
    .clk        (clk),
    .reset      (reset),
    .WR         (WR),
    .ADDR_WR    (ADDR_WR),
    .DIN        (DIN),
    .BSEL       (BSEL),
    .RD         (RD),
    .ADDR_RD    (ADDR_RD),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .ERR_WR     (ERR_WR),
    .ERR_RD     (ERR_RD),
    .WR_CNT     (WR_CNT),
    .RD_CNT     (RD_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] awr;
    logic [63:0] din;
    logic [7:0]  bsel;
    logic        rd;
    logic [31:0] ard;
    logic        exp_err_wr;
    logic [63:0] exp_dout;
    logic        exp_err_rd;
  } vec_t;

  typedef struct {
    logic [63:0] dout;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[16];
  int          total = 0;
  int          bad = 0;
  logic [63:0] last_dout = '0;
  int          valid_seen = 0;
  logic [31:0] exp_wr_cnt = '0;
  logic [31:0] exp_rd_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
    return (a >> 13) != 0;
  endfunction

  // Read-side scoreboard: every DOUT_VALID must match the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (DOUT_VALID === 1'b1) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(DOUT_VALID), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dout", DOUT, e.dout);
          chk("err_rd", 64'(ERR_RD), 64'(e.err));
          last_dout = e.dout;
        end
      end else begin
        chk("dout_hold", DOUT, last_dout);
        chk("err_rd_idle", 64'(ERR_RD), 64'd0);
      end
    end
  end

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    WR = v.wr; ADDR_WR = v.awr; DIN = v.din; BSEL = v.bsel;
    RD = v.rd; ADDR_RD = v.ard;
    if (v.rd) begin
      e.dout = v.exp_dout;
      e.err  = v.exp_err_rd;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v.wr && !oor(v.awr)) exp_wr_cnt = exp_wr_cnt + 32'd1;
    if (v.rd && !oor(v.ard)) exp_rd_cnt = exp_rd_cnt + 32'd1;
    chk({nm, "_err_wr"}, 64'(ERR_WR), 64'(v.exp_err_wr));
    chk({nm, "_wr_cnt"}, 64'(WR_CNT), 64'(exp_wr_cnt));
    chk({nm, "_rd_cnt"}, 64'(RD_CNT), 64'(exp_rd_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      WR = 1'b0; RD = 1'b0; BSEL = '0;
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; WR = 1'b0; RD = 1'b0; ADDR_WR = '0; ADDR_RD = '0; DIN = '0; BSEL = '0;

    vecs[0]  = '{1'b1, 32'h10,   64'h1122334455667788, 8'hFF, 1'b0, 32'h0,        1'b0, 64'h0,                1'b0};
    vecs[1]  = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b1, 32'h10,       1'b0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0, 32'h0,        1'b0, 64'h0,                1'b0};
    vecs[3]  = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b1, 32'h10,       1'b0, 64'h11223344BBBBBBBB, 1'b0};
    vecs[4]  = '{1'b1, 32'h20,   64'h0,                8'hFF, 1'b0, 32'h0,        1'b0, 64'h0,                1'b0};
    vecs[5]  = '{1'b1, 32'h20,   64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b1, 32'h20,       1'b0, 64'hFFFFFFFF00000000, 1'b0};
    vecs[6]  = '{1'b1, 32'h2000, 64'h5,                8'hFF, 1'b0, 32'h0,        1'b1, 64'h0,                1'b0};
    vecs[7]  = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b1, 32'h2000,     1'b0, 64'hDEADBEEF,         1'b1};
    vecs[8]  = '{1'b1, 32'h18,   64'h0123456789ABCDEF, 8'hFF, 1'b1, 32'h10,       1'b0, 64'h11223344BBBBBBBB, 1'b0};
    vecs[9]  = '{1'b1, 32'h18,   64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 32'h1F,       1'b0, 64'h0123456789ABCDEF, 1'b0};
    vecs[10] = '{1'b1, 32'h4010, 64'h0,                8'hFF, 1'b1, 32'h10,       1'b1, 64'h11223344BBBBBBBB, 1'b0};
    vecs[11] = '{1'b1, 32'h1FF8, 64'hCAFEF00D12345678, 8'hFF, 1'b0, 32'h0,        1'b0, 64'h0,                1'b0};
    vecs[12] = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b1, 32'h1FFF,     1'b0, 64'hCAFEF00D12345678, 1'b0};
    vecs[13] = '{1'b1, 32'h20,   64'h0123456789ABCDEF, 8'h3C, 1'b1, 32'h80000010, 1'b0, 64'hDEADBEEF,         1'b1};
    vecs[14] = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b1, 32'h20,       1'b0, 64'hFFFF456789AB0000, 1'b0};
    vecs[15] = '{1'b0, 32'h0,    64'h0,                8'h00, 1'b0, 32'h0,        1'b0, 64'h0,                1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_dout", DOUT, 64'd0);
    chk("rst_valid", 64'(DOUT_VALID), 64'd0);
    chk("rst_err", 64'({ERR_WR, ERR_RD}), 64'd0);
    chk("rst_cnt", {WR_CNT, RD_CNT}, 64'd0);

    for (int i = 0; i < 16; i++) apply(vecs[i], $sformatf("vec%0d", i));
    idle(2);

    // Reset asserted together with a read: no response, counters cleared, array kept.
    @(negedge clk);
    reset = 1'b1; RD = 1'b1; ADDR_RD = 32'h10;
    last_dout = '0;
    exp_wr_cnt = '0;
    exp_rd_cnt = '0;
    @(negedge clk);
    reset = 1'b0; RD = 1'b0;
    chk("rstrd_valid", 64'(DOUT_VALID), 64'd0);
    chk("rstrd_dout", DOUT, 64'd0);
    chk("rstrd_cnt", {WR_CNT, RD_CNT}, 64'd0);
    v = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h10, 1'b0, 64'h11223344BBBBBBBB, 1'b0};
    apply(v, "post_rst_rd");
    idle(2);

    // Write counter wrap from a forced preload.
    @(negedge clk);
    force dut.WR_CNT = 32'hFFFF_FFFF;
    #1;
    release dut.WR_CNT;
    exp_wr_cnt = 32'hFFFF_FFFF;
    chk("preload_wr_cnt", 64'(WR_CNT), 64'hFFFF_FFFF);
    v = '{1'b1, 32'h30, 64'h1, 8'hFF, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0};
    apply(v, "wrap");
    chk("wrap_zero", 64'(WR_CNT), 64'd0);
    idle(2);

    // Eight back-to-back reads: DOUT_VALID high for exactly eight cycles.
    @(negedge clk);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h0, 1'b0, 64'h0, 1'b0};
      case (i % 4)
        0: begin v.ard = 32'h10;   v.exp_dout = 64'h11223344BBBBBBBB; end
        1: begin v.ard = 32'h18;   v.exp_dout = 64'h0123456789ABCDEF; end
        2: begin v.ard = 32'h1FF8; v.exp_dout = 64'hCAFEF00D12345678; end
        default: begin v.ard = 32'h30; v.exp_dout = 64'h1; end
      endcase
      apply(v, $sformatf("b2b%0d", i));
    end
    idle(4);
    chk("b2b_valid_cycles", 64'(valid_seen), 64'd8);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
